// File: rtl/wt_dcache_store_wbuf.sv
// -----------------------------------------------------------------------------
// wt_dcache_store_wbuf
//
// Write buffer between the store unit and the write-through dcache memory port.
// Committed stores are held in a DEPTH-entry circular FIFO. They are issued to
// memory in program order. Each entry is held until memory acknowledges it by
// TID (TID = entry index). Acks may return out of order. Loads can query the
// buffer for a same-word hazard, so a load never bypasses an older store.
//
// Optional feature (compile-time macro WT_WBUF_MERGE_EN):
//   When defined, a store to the same word as the youngest entry merges into
//   that entry, provided the entry is still PEND and is not being handed to
//   memory this cycle. When undefined, every accepted store allocates a new
//   entry.
//
// Ports
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   st_valid_i / st_ready_o       store request handshake
//   st_addr_i, st_data_i, st_be_i store byte address, lane-aligned data, BEs
//   mem_valid_o / mem_ready_i     write request handshake towards memory
//   mem_addr_o, mem_data_o,
//   mem_be_o, mem_tid_o           request payload (word-aligned address)
//   ack_valid_i, ack_tid_i        write acknowledge from memory
//   ld_addr_i / ld_hit_o          load hazard query (combinational)
//   empty_o                       no entry in flight (fence / flush drain)
// -----------------------------------------------------------------------------
module wt_dcache_store_wbuf #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TID_W  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  st_valid_i,
    output logic                  st_ready_o,
    input  logic [ADDR_W-1:0]     st_addr_i,
    input  logic [DATA_W-1:0]     st_data_i,
    input  logic [DATA_W/8-1:0]   st_be_i,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_data_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [TID_W-1:0]      mem_tid_o,
    input  logic                  ack_valid_i,
    input  logic [TID_W-1:0]      ack_tid_i,
    input  logic [ADDR_W-1:0]     ld_addr_i,
    output logic                  ld_hit_o,
    output logic                  empty_o
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    // Clears the byte-offset bits so that addresses compare at word granularity.
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BE_W - 1);

    typedef enum logic [1:0] {
        ENT_INV  = 2'd0,
        ENT_PEND = 2'd1,
        ENT_SENT = 2'd2
    } ent_state_e;

    ent_state_e         state_q [DEPTH];
    ent_state_e         state_d [DEPTH];
    logic [ADDR_W-1:0]  addr_q  [DEPTH];
    logic [DATA_W-1:0]  data_q  [DEPTH];
    logic [BE_W-1:0]    be_q    [DEPTH];

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W-1:0]   issue_ptr;
    logic               issue_found;
    logic               issue_fire;
    logic               merge_hit;
    logic               st_accept;
    logic               alloc;

    logic [DEPTH-1:0]   valid_vec;
    logic [DEPTH-1:0]   hit_vec;
    logic [DEPTH-1:0]   ack_vec;

    logic [ADDR_W-1:0]  st_waddr;
    logic [ADDR_W-1:0]  ld_waddr;

    assign st_waddr = st_addr_i & WORD_MASK;
    assign ld_waddr = ld_addr_i & WORD_MASK;

    // Per-entry status: occupancy, load hazard match, and ack match. An ack
    // only frees an entry that is actually SENT; anything else is dropped.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign valid_vec[gi] = (state_q[gi] != ENT_INV);
            assign hit_vec[gi]   = valid_vec[gi] && (addr_q[gi] == ld_waddr);
            assign ack_vec[gi]   = ack_valid_i && (ack_tid_i == TID_W'(gi))
                                   && (state_q[gi] == ENT_SENT);
        end
    endgenerate

    // Oldest PEND entry: walk the ring in age order starting at the head.
    // The head never lags behind an allocation into its own slot (it steps off
    // in the same cycle), so this walk visits entries oldest-first.
    always_comb begin
        issue_found = 1'b0;
        issue_ptr   = head_q;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!issue_found && (state_q[head_q + PTR_W'(k)] == ENT_PEND)) begin
                issue_found = 1'b1;
                issue_ptr   = head_q + PTR_W'(k);
            end
        end
    end

    assign mem_valid_o = issue_found;
    assign issue_fire  = issue_found && mem_ready_i;
    assign mem_addr_o  = addr_q[issue_ptr];
    assign mem_data_o  = data_q[issue_ptr];
    assign mem_be_o    = be_q[issue_ptr];
    assign mem_tid_o   = TID_W'(issue_ptr);

`ifdef WT_WBUF_MERGE_EN
    logic [PTR_W-1:0] young_ptr;
    logic             do_merge;

    // The youngest entry sits just behind the tail. Merging into a request
    // that memory is taking this cycle would lose the new bytes, so that case
    // allocates instead. A request still waiting on mem_ready_i may be
    // updated: memory has not taken it yet.
    assign young_ptr = tail_q - PTR_W'(1);
    assign merge_hit = st_valid_i
                       && (state_q[young_ptr] == ENT_PEND)
                       && !(issue_fire && (issue_ptr == young_ptr))
                       && (addr_q[young_ptr] == st_waddr);
    assign do_merge  = st_accept && merge_hit;
`else
    assign merge_hit = 1'b0;
`endif

    // Ready only looks at registered state, so an ack freeing the tail this
    // cycle opens the buffer from the next cycle on.
    assign st_ready_o = (state_q[tail_q] == ENT_INV) || merge_hit;
    assign st_accept  = st_valid_i && st_ready_o;
    assign alloc      = st_accept && !merge_hit;

    assign empty_o  = ~|valid_vec;
    assign ld_hit_o = |hit_vec;

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                ENT_INV:  if (alloc && (tail_q == PTR_W'(k)))           state_d[k] = ENT_PEND;
                ENT_PEND: if (issue_fire && (issue_ptr == PTR_W'(k)))   state_d[k] = ENT_SENT;
                ENT_SENT: if (ack_vec[k])                               state_d[k] = ENT_INV;
                default:                                                state_d[k] = ENT_INV;
            endcase
        end
    end

    // The head steps over freed slots one at a time while anything is still
    // in flight, so out-of-order acks never leave holes ahead of the head.
    always_comb begin
        head_d = head_q;
        if ((state_q[head_q] == ENT_INV) && (|valid_vec)) begin
            head_d = head_q + PTR_W'(1);
        end
        tail_d = alloc ? (tail_q + PTR_W'(1)) : tail_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                state_q[k] <= ENT_INV;
            end
            head_q <= '0;
            tail_q <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                state_q[k] <= state_d[k];
            end
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Payload is qualified by the entry state, so it needs no reset.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (alloc && (tail_q == PTR_W'(k))) begin
                addr_q[k] <= st_waddr;
                data_q[k] <= st_data_i;
                be_q[k]   <= st_be_i;
            end
`ifdef WT_WBUF_MERGE_EN
            else if (do_merge && (young_ptr == PTR_W'(k))) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (st_be_i[b]) begin
                        data_q[k][8*b +: 8] <= st_data_i[8*b +: 8];
                    end
                end
                be_q[k] <= be_q[k] | st_be_i;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wt_dcache_store_wbuf.sv
// -----------------------------------------------------------------------------
// Testbench for wt_dcache_store_wbuf (default sizing: DEPTH=2, 32-bit, TID_W=2).
// Expected memory requests are queued as stores are driven and compared as
// the buffer issues them. Build with +define+WT_WBUF_MERGE_EN to cover merging.
// -----------------------------------------------------------------------------
module tb_wt_dcache_store_wbuf;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        st_valid_i;
    logic        st_ready_o;
    logic [31:0] st_addr_i;
    logic [31:0] st_data_i;
    logic [3:0]  st_be_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_be_o;
    logic [1:0]  mem_tid_o;
    logic        ack_valid_i;
    logic [1:0]  ack_tid_i;
    logic [31:0] ld_addr_i;
    logic        ld_hit_o;
    logic        empty_o;

    always #5 clk_i = ~clk_i;

    wt_dcache_store_wbuf #(
        .DEPTH (2),
        .ADDR_W(32),
        .DATA_W(32),
        .TID_W (2)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .st_valid_i (st_valid_i),
        .st_ready_o (st_ready_o),
        .st_addr_i  (st_addr_i),
        .st_data_i  (st_data_i),
        .st_be_i    (st_be_i),
        .mem_valid_o(mem_valid_o),
        .mem_ready_i(mem_ready_i),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_be_o   (mem_be_o),
        .mem_tid_o  (mem_tid_o),
        .ack_valid_i(ack_valid_i),
        .ack_tid_i  (ack_tid_i),
        .ld_addr_i  (ld_addr_i),
        .ld_hit_o   (ld_hit_o),
        .empty_o    (empty_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [1:0]  tid;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;
    int   tail_m = 0;   // slot the next allocation lands in
    int   stale_tid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        exp_t e;
        e.addr = a & 32'hFFFF_FFFC;
        e.data = d;
        e.be   = b;
        e.tid  = 2'(tail_m);
        sb.push_back(e);
        tail_m = (tail_m + 1) % 2;
    endtask

    // Drive a store that must be accepted as a new entry.
    task automatic store_acc(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b);
        st_valid_i = 1'b1;
        st_addr_i  = a;
        st_data_i  = d;
        st_be_i    = b;
        #1;
        chk({tag, "_st_ready"}, st_ready_o, 1);
        push_exp(a, d, b);
        tick();
        st_valid_i = 1'b0;
        $display("store %s addr=0x%08h data=0x%08h be=0x%0h", tag, a, d, b);
    endtask

    // Let memory take the next request and compare it to the scoreboard head.
    task automatic issue_one(input string tag);
        int   n;
        exp_t e;
        n = 0;
        mem_ready_i = 1'b1;
        #1;
        while (mem_valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_mem_valid"}, mem_valid_o, 1);
        if (mem_valid_o === 1'b1 && sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_mem_addr"}, mem_addr_o, e.addr);
            chk({tag, "_mem_data"}, mem_data_o, e.data);
            chk({tag, "_mem_be"},   mem_be_o,   e.be);
            chk({tag, "_mem_tid"},  mem_tid_o,  e.tid);
            $display("issue %s addr=0x%08h data=0x%08h be=0x%0h tid=%0d",
                     tag, mem_addr_o, mem_data_o, mem_be_o, mem_tid_o);
        end
        tick();
        mem_ready_i = 1'b0;
    endtask

    task automatic ack(input int tid);
        ack_valid_i = 1'b1;
        ack_tid_i   = 2'(tid);
        tick();
        ack_valid_i = 1'b0;
        $display("ack tid=%0d", tid);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        sb.delete();
        tail_m = 0;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni      = 1'b0;
        st_valid_i  = 1'b0;
        st_addr_i   = '0;
        st_data_i   = '0;
        st_be_i     = '0;
        mem_ready_i = 1'b0;
        ack_valid_i = 1'b0;
        ack_tid_i   = '0;
        ld_addr_i   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_st_ready",  st_ready_o,  1);
        chk("rst_mem_valid", mem_valid_o, 0);
        chk("rst_ld_hit",    ld_hit_o,    0);
        chk("rst_empty",     empty_o,     1);
        rst_ni = 1'b1;
        tick();

        // 1. Single store, issue, ack
        mem_ready_i = 1'b1;
        store_acc("t1", 32'h8000_0004, 32'hDEAD_BEEF, 4'hF);
        issue_one("t1");
        #1;
        chk("t1_sent_not_empty", empty_o,     0);
        chk("t1_sent_no_valid",  mem_valid_o, 0);
        ack(0);
        chk("t1_empty_after_ack", empty_o, 1);

        // 2. Fill and block, ack opens the buffer only on the next cycle
        do_reset();
        mem_ready_i = 1'b0;
        store_acc("t2a", 32'h8000_0020, 32'h1111_1111, 4'hF);
        store_acc("t2b", 32'h8000_0040, 32'h2222_2222, 4'hF);
        st_valid_i = 1'b1;
        st_addr_i  = 32'h8000_0060;
        st_data_i  = 32'h3333_3333;
        st_be_i    = 4'hF;
        #1;
        chk("t2_full_st_ready", st_ready_o, 0);
        issue_one("t2a");
        issue_one("t2b");
        ack_valid_i = 1'b1;
        ack_tid_i   = 2'd0;
        #1;
        chk("t2_ack_same_cycle_ready", st_ready_o, 0);
        tick();
        ack_valid_i = 1'b0;
        #1;
        chk("t2_ready_after_ack", st_ready_o, 1);
        push_exp(32'h8000_0060, 32'h3333_3333, 4'hF);
        tick();
        st_valid_i = 1'b0;
        $display("store t2c addr=0x80000060 accepted after ack");
        issue_one("t2c");
        ack(1);
        ack(0);
        chk("t2_empty", empty_o, 1);

        // 3. Out-of-order ack
        do_reset();
        store_acc("t3x", 32'h8000_0100, 32'hA0A0_A0A0, 4'hF);
        store_acc("t3y", 32'h8000_0200, 32'hB0B0_B0B0, 4'hF);
        issue_one("t3x");
        issue_one("t3y");
        ack(1);
        chk("t3_not_empty", empty_o, 0);
        st_valid_i = 1'b1;
        st_addr_i  = 32'h8000_0300;
        st_data_i  = 32'hC0C0_C0C0;
        st_be_i    = 4'hF;
        #1;
        chk("t3_no_alloc_slot0", st_ready_o,  0);
        chk("t3_no_request",     mem_valid_o, 0);
        st_valid_i = 1'b0;
        ack(0);
        chk("t3_empty",    empty_o,    1);
        chk("t3_st_ready", st_ready_o, 1);

        // 4. Load hazard, PEND and SENT
        store_acc("t4", 32'h8000_0010, 32'h5A5A_5A5A, 4'hF);
        ld_addr_i = 32'h8000_0013;
        #1;
        chk("t4_hit_same_word", ld_hit_o, 1);
        ld_addr_i = 32'h8000_0014;
        #1;
        chk("t4_miss_next_word", ld_hit_o, 0);
        issue_one("t4");
        ld_addr_i = 32'h8000_0010;
        #1;
        chk("t4_hit_sent", ld_hit_o, 1);
        ack(0);
        chk("t4_miss_after_ack", ld_hit_o, 0);
        ld_addr_i = '0;

        // 5. Same-word stores, memory stalled
        store_acc("t5a", 32'h0000_0100, 32'h0000_00AA, 4'h1);
        st_valid_i = 1'b1;
        st_addr_i  = 32'h0000_0101;
        st_data_i  = 32'h0000_BB00;
        st_be_i    = 4'h2;
        #1;
        chk("t5b_st_ready", st_ready_o, 1);
`ifdef WT_WBUF_MERGE_EN
        begin
            exp_t e;
            e      = sb[sb.size()-1];
            e.data = (e.data & 32'hFFFF_00FF) | 32'h0000_BB00;
            e.be   = e.be | 4'h2;
            sb[sb.size()-1] = e;
        end
`else
        push_exp(32'h0000_0101, 32'h0000_BB00, 4'h2);
`endif
        tick();
        st_valid_i = 1'b0;
        $display("store t5b addr=0x00000101 data=0x0000bb00 be=0x2");
        st_valid_i = 1'b1;
        st_addr_i  = 32'h0000_0200;
        st_data_i  = '0;
        st_be_i    = 4'hF;
        #1;
`ifdef WT_WBUF_MERGE_EN
        chk("t5_one_entry_room_left", st_ready_o, 1);
`else
        chk("t5_two_entries_full", st_ready_o, 0);
`endif
        st_valid_i = 1'b0;
        issue_one("t5_first");
`ifdef WT_WBUF_MERGE_EN
        ack(1);
`else
        issue_one("t5_second");
        ack(1);
        ack(0);
`endif
        chk("t5_empty", empty_o, 1);

        // 6. Reset while an entry is SENT, then a stale ack
        stale_tid = tail_m;
        store_acc("t6", 32'h8000_0080, 32'h6666_6666, 4'hF);
        issue_one("t6");
        chk("t6_sent_not_empty", empty_o, 0);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_empty",     empty_o,     1);
        chk("t6_rst_mem_valid", mem_valid_o, 0);
        chk("t6_rst_st_ready",  st_ready_o,  1);
        sb.delete();
        tail_m = 0;
        tick();
        rst_ni = 1'b1;
        tick();
        ack(stale_tid);
        chk("t6_stale_ack_empty",     empty_o,     1);
        chk("t6_stale_ack_mem_valid", mem_valid_o, 0);
        store_acc("t6n", 32'h8000_0090, 32'h7777_7777, 4'hF);
        issue_one("t6n");
        chk("t6n_not_empty", empty_o, 0);
        ack(0);
        chk("t6n_empty", empty_o, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
